score_display: RTL
==================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of display digits, legal 1..8.
REQ-002 SHALL have parameter BIN_W, default 16: width of the binary input, legal 4..27.
REQ-003 SHALL have parameter SCAN_DIV, default 17: width of the refresh divider; one digit slot lasts 2^SCAN_DIV cycles.
REQ-004 SHALL have parameter ACT_LOW, default 1: 1 makes anode and ssdOut active-low; 0 makes them active-high.
REQ-005 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port load, input, 1: one-cycle request to display value.
REQ-008 SHALL have port value, input, BIN_W: unsigned binary number to display.
REQ-009 SHALL have port blank_lz, input, 1: 1 blanks leading zeros.
REQ-010 SHALL have port busy, output, 1: high while a conversion runs.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a conversion commits to the display.
REQ-012 SHALL have port overflow, output, 1: high when the committed value exceeds 10^DIGITS-1.
REQ-013 SHALL have port anode, output, DIGITS: one-hot digit enable.
REQ-014 SHALL have port ssdOut, output, 7: segments {a,b,c,d,e,f,g}, with a on bit 6.

Function
REQ-015 SHALL accept load while idle: capture value into a shift register, clear the BCD accumulator, and assert busy on the next cycle.
REQ-016 SHALL convert with shift-add-3 (double dabble), one bit per cycle, in FSM states IDLE -> SHIFT (BIN_W cycles) -> COMMIT (1 cycle) -> IDLE.
REQ-017 SHALL hold busy high for exactly BIN_W+1 cycles.
REQ-018 SHALL, in COMMIT, copy the BCD accumulator to the display register, update overflow, and pulse done for one cycle.
REQ-019 SHALL keep a one-deep pending slot for load during busy: store value and set the pending flag; a later load during busy overwrites the slot (latest value wins).
REQ-020 SHALL, after COMMIT with the pending flag set, clear the flag and enter SHIFT with the pending value on the next cycle, with no IDLE cycle.
REQ-021 SHALL, on load in the same cycle as COMMIT, treat it as pending.
REQ-022 SHALL set an internal sticky overflow when any 1 shifts out of the top BCD digit during SHIFT; this flag is cleared at the start of each conversion.
REQ-023 SHALL, when overflow=1, drive segment g only (a dash) on every digit and ignore blank_lz.
REQ-024 SHALL increment a free-running SCAN_DIV-bit refresh counter every cycle.
REQ-025 SHALL advance the digit index on refresh-counter wrap, wrapping from DIGITS-1 to 0.
REQ-026 SHALL assert anode[i] only for i equal to the digit index.
REQ-027 SHALL, when blank_lz=1, deassert anode for digits above the most-significant nonzero digit; digit 0 always displays.
REQ-028 SHALL decode hex 0-9 to standard segment patterns; codes A-F cannot occur.
REQ-029 SHALL apply ACT_LOW polarity to anode and ssdOut only, never to internal state.
REQ-030 SHALL register anode and ssdOut, giving a 1-cycle lag from the digit index.
REQ-031 SHALL leave the display register unchanged while busy, so no partial BCD result is ever shown.

Reset
REQ-032 SHALL, on Reset_n low, immediately clear FSM to IDLE, busy=0, done=0, overflow=0, pending=0, refresh counter=0, digit index=0, and display register=0.
REQ-033 SHALL, during reset, drive anode with digit 0 active only and ssdOut with the glyph "0", polarity per ACT_LOW.
REQ-034 SHALL, on reset release, wait for the first rising Clk edge before any state change.
REQ-035 SHALL, on reset mid-conversion, discard both the conversion and the pending value.

Verification (DIGITS=4, BIN_W=16, SCAN_DIV=2, ACT_LOW=1)
REQ-036 SHALL cover: load value=1234 -> busy high 17 cycles, done pulses once, digits 3..0 show 1,2,3,4, overflow=0.
REQ-037 SHALL cover: load 65535 -> overflow=1, every digit ssdOut=7'b1111110.
REQ-038 SHALL cover: blank_lz=1, load 7 -> anode[0] low in its slot, anode[3:1] never low; with blank_lz=0, the same value shows 0007.
REQ-039 SHALL cover: load 1111, then 2222 at busy cycle 5, then 3333 at busy cycle 6 -> 1111 commits, 3333 converts back-to-back, 2222 never displayed, two done pulses.
REQ-040 SHALL cover: Reset_n low at busy cycle 8 of 4321 -> busy=0 and display 0000 at once; no done pulse after release.
REQ-041 SHALL cover: idle scan -> digit index sequence 0,1,2,3,0, each held 4 cycles, anode one-hot throughout.

Source files
------------

// File: rtl/score_display.sv
// Binary-to-BCD score display: double-dabble converter with a one-deep pending load,
// committed BCD register, and a multiplexed seven-segment scanner.
module score_display #(
  parameter int DIGITS   = 8,
  parameter int BIN_W    = 16,
  parameter int SCAN_DIV = 17,
  parameter int ACT_LOW  = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  value,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        ssdOut
);

  // state  | meaning
  // IDLE   | waiting for load
  // SHIFT  | one double-dabble step per cycle, BIN_W cycles
  // COMMIT | copy BCD to display, pulse done, chain pending load
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic INV = (ACT_LOW != 0);

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shreg_q, shreg_d, pend_val_q, pend_val_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, disp_q, disp_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, sticky_d, pend_q, pend_d;
  logic                done_q, done_d, overflow_q, overflow_d;
  logic [SCAN_DIV-1:0] refresh_q, refresh_d;
  logic [IDX_W-1:0]    dig_idx_q, dig_idx_d, msd;
  logic [DIGITS-1:0]   anode_q, anode_d, anode_on;
  logic [6:0]          ssd_q, ssd_d;
  logic [3:0]          nib;
  logic                start_chain;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      refresh_q  <= '0;
      dig_idx_q  <= '0;
      anode_q    <= INV ? ~DIGITS'(1) : DIGITS'(1);
      ssd_q      <= INV ? ~seg_of(4'd0) : seg_of(4'd0);
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      refresh_q  <= refresh_d;
      dig_idx_q  <= dig_idx_d;
      anode_q    <= anode_d;
      ssd_q      <= ssd_d;
    end
  end

  // A load landing on the COMMIT cycle counts as pending and wins over the stored slot.
  assign start_chain = pend_q | load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == '0) state_d = S_COMMIT;
      S_COMMIT: state_d = start_chain ? S_SHIFT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    overflow = overflow_q;
    anode    = anode_q;
    ssdOut   = ssd_q;
  end

  always_comb begin
    shreg_d    = shreg_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shreg_d  = value;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W - 1);
        end
      end
      S_SHIFT: begin
        shreg_d  = shreg_q << 1;
        bcd_d    = {bcd_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
        sticky_d = sticky_q | bcd_adj[BCD_W-1];
        cnt_d    = cnt_q - 1'b1;
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      S_COMMIT: begin
        disp_d     = bcd_q;
        overflow_d = sticky_q;
        done_d     = 1'b1;
        if (start_chain) begin
          shreg_d  = load ? value : pend_val_q;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W - 1);
          pend_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Scanner: anode/ssd are registered from the current digit index (one-cycle lag).
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (refresh_q == '1)
      dig_idx_d = (dig_idx_q == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
    nib      = 4'd0;
    msd      = '0;
    anode_on = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx_q == IDX_W'(i)) begin
        nib         = disp_q[4*i +: 4];
        anode_on[i] = 1'b1;
      end
      if (disp_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    if (blank_lz && !overflow_q && (dig_idx_q > msd)) anode_on = '0;
    anode_d = INV ? ~anode_on : anode_on;
    ssd_d   = overflow_q ? 7'b0000001 : seg_of(nib);
    if (INV) ssd_d = ~ssd_d;
  end

endmodule
